pipeline_ctrl: RTL and testbench

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

---
 rtl/pipeline_pkg.sv | 13 +
 rtl/hazard_detect.sv | 16 +
 rtl/pipeline_ctrl.sv | 150 +++++++++++++++
 tb/tb_pipeline_ctrl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard/stall controller.
// Holds the FSM state encoding and the register-index width.
package pipeline_pkg;

  localparam int REG_IDX_W = 5;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_MEM_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_t;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard compare between the load in EX and the sources in ID.
// Pure combinational; r0 is hardwired zero, so it never creates a dependency.
module hazard_detect
  import pipeline_pkg::*;
(
  input  logic                 i_idex_memread,
  input  logic [REG_IDX_W-1:0] i_idex_rd,
  input  logic [REG_IDX_W-1:0] i_ifid_rs,
  input  logic [REG_IDX_W-1:0] i_ifid_rt,
  output logic                 o_hazard
);

  assign o_hazard = i_idex_memread && (i_idex_rd != '0) &&
                    ((i_idex_rd == i_ifid_rs) || (i_idex_rd == i_ifid_rt));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline stall/flush controller: memory-wait FSM with timeout, branch flush,
// load-use bubble and a saturating stall/flush event counter.
//
// state    | meaning
// RUN      | normal flow; branch flush and load-use bubble handled here
// MEM_WAIT | data memory busy, whole pipeline frozen, counting wait cycles
// ERR      | memory timeout, pipeline frozen until reset
module pipeline_ctrl
  import pipeline_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   idex_memread,
  input  logic [REG_IDX_W-1:0]   idex_rd,
  input  logic [REG_IDX_W-1:0]   ifid_rs,
  input  logic [REG_IDX_W-1:0]   ifid_rt,
  input  logic                   branch_taken,
  input  logic                   mem_req,
  input  logic                   mem_ready,
  output logic                   pc_en,
  output logic                   ifid_en,
  output logic                   idex_en,
  output logic                   exmem_en,
  output logic                   memwb_en,
  output logic                   ifid_flush,
  output logic                   idex_flush,
  output logic                   memwb_bubble,
  output logic                   mem_timeout_err,
  output logic [1:0]             state,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  logic [1:0]             r_state;
  logic [WAIT_W-1:0]      r_wait_cnt;
  logic                   r_err;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  state_t            w_state_dec;
  state_t            w_state_nxt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              w_hazard;
  logic              w_run_flow;
  logic              w_stall_evt;
  logic [4:0]        w_en;
  logic [2:0]        w_fl;

  hazard_detect u_hazard_detect (
    .i_idex_memread (idex_memread),
    .i_idex_rd      (idex_rd),
    .i_ifid_rs      (ifid_rs),
    .i_ifid_rt      (ifid_rt),
    .o_hazard       (w_hazard)
  );

  // The unused encoding 2'b01 falls into the default arm and behaves as RUN.
  always_comb begin
    case (r_state)
      2'd2:    w_state_dec = ST_MEM_WAIT;
      2'd3:    w_state_dec = ST_ERR;
      default: w_state_dec = ST_RUN;
    endcase
  end

  // w_en = {pc, ifid, idex, exmem, memwb}; w_fl = {ifid_flush, idex_flush, memwb_bubble}
  always_comb begin
    w_state_nxt = w_state_dec;
    w_wait_nxt  = r_wait_cnt;
    w_run_flow  = 1'b0;
    w_en        = 5'b11111;
    w_fl        = 3'b000;
    case (w_state_dec)
      ST_ERR: begin
        w_en = 5'b00000;
      end
      ST_MEM_WAIT: begin
        if (mem_ready) begin
          w_state_nxt = ST_RUN;
          w_run_flow  = 1'b1;
        end else begin
          w_en       = 5'b00000;
          w_fl       = 3'b001;
          w_wait_nxt = r_wait_cnt + WAIT_W'(1);
          if (r_wait_cnt == WAIT_W'(MEM_TIMEOUT - 1)) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      default: begin
        if (mem_req && !mem_ready) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = '0;
          w_en        = 5'b00000;
          w_fl        = 3'b001;
        end else begin
          w_run_flow = 1'b1;
        end
      end
    endcase
    // Branch squashes the dependent instruction anyway, so it wins over load-use.
    if (w_run_flow) begin
      if (branch_taken) begin
        w_fl = 3'b110;
      end else if (w_hazard) begin
        w_en = 5'b00111;
        w_fl = 3'b010;
      end
    end
  end

  assign w_stall_evt = (w_en != 5'b11111) || (w_fl != 3'b000);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_wait_cnt  <= '0;
      r_err       <= 1'b0;
      r_stall_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_nxt;
      if (w_state_nxt == ST_ERR) begin
        r_err <= 1'b1;
      end
      if (w_stall_evt && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      end
    end
  end

  // During reset every stage loads a bubble so the pipeline comes up clean.
  always_comb begin
    if (!rst_n) begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = 5'b11111;
      {ifid_flush, idex_flush, memwb_bubble}        = 3'b111;
    end else begin
      {pc_en, ifid_en, idex_en, exmem_en, memwb_en} = w_en;
      {ifid_flush, idex_flush, memwb_bubble}        = w_fl;
    end
  end

  assign mem_timeout_err = r_err;
  assign state           = r_state;
  assign stall_cnt       = r_stall_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Scoreboard bench for pipeline_ctrl: directed scenarios plus random traffic,
// expected outputs from a cycle-level behavioural model of the controller rules.
module tb_pipeline_ctrl;

  localparam int TO     = 15;
  localparam int SCW    = 16;
  localparam int SC_MAX = (1 << SCW) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            idex_memread = 1'b0;
  logic [4:0]      idex_rd = '0;
  logic [4:0]      ifid_rs = '0;
  logic [4:0]      ifid_rt = '0;
  logic            branch_taken = 1'b0;
  logic            mem_req = 1'b0;
  logic            mem_ready = 1'b0;
  logic            pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic            ifid_flush, idex_flush, memwb_bubble;
  logic            mem_timeout_err;
  logic [1:0]      state;
  logic [SCW-1:0]  stall_cnt;

  pipeline_ctrl #(.MEM_TIMEOUT(TO), .STALL_CNT_W(SCW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .idex_memread    (idex_memread),
    .idex_rd         (idex_rd),
    .ifid_rs         (ifid_rs),
    .ifid_rt         (ifid_rt),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .idex_en         (idex_en),
    .exmem_en        (exmem_en),
    .memwb_en        (memwb_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .memwb_bubble    (memwb_bubble),
    .mem_timeout_err (mem_timeout_err),
    .state           (state),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  en;
    logic [2:0]  fl;
    logic        err;
    logic [1:0]  st;
    logic [15:0] sc;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Model of the controller as a few plain facts about the pipeline.
  bit m_waiting = 0;
  bit m_err = 0;
  int m_wait_cycles = 0;
  int m_stalls = 0;

  function automatic exp_t model_out(bit rst, bit ld, logic [4:0] rd, logic [4:0] rs,
                                     logic [4:0] rt, bit br, bit req, bit rdy);
    exp_t e;
    bit hz;
    hz = ld && (rd != 0) && (rd == rs || rd == rt);
    e.err = m_err;
    e.st  = m_err ? 2'd3 : (m_waiting ? 2'd2 : 2'd0);
    e.sc  = 16'(m_stalls);
    if (!rst) begin
      e.en = 5'b11111; e.fl = 3'b111;
    end else if (m_err) begin
      e.en = 5'b00000; e.fl = 3'b000;
    end else if ((m_waiting && !rdy) || (!m_waiting && req && !rdy)) begin
      e.en = 5'b00000; e.fl = 3'b001;
    end else if (br) begin
      e.en = 5'b11111; e.fl = 3'b110;
    end else if (hz) begin
      e.en = 5'b00111; e.fl = 3'b010;
    end else begin
      e.en = 5'b11111; e.fl = 3'b000;
    end
    return e;
  endfunction

  task automatic model_step(bit rst, bit req, bit rdy, exp_t e);
    if (!rst) begin
      m_waiting = 0; m_err = 0; m_wait_cycles = 0; m_stalls = 0;
    end else begin
      if ((e.en != 5'b11111 || e.fl != 3'b000) && m_stalls < SC_MAX) m_stalls++;
      if (m_err) begin
        m_err = 1;
      end else if (m_waiting) begin
        if (rdy) m_waiting = 0;
        else begin
          m_wait_cycles++;
          if (m_wait_cycles >= TO) begin m_err = 1; m_waiting = 0; end
        end
      end else if (req && !rdy) begin
        m_waiting = 1; m_wait_cycles = 0;
      end
    end
  endtask

  task automatic drive(bit rst, bit ld, logic [4:0] rd, logic [4:0] rs, logic [4:0] rt,
                       bit br, bit req, bit rdy);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = rst; idex_memread = ld; idex_rd = rd; ifid_rs = rs; ifid_rt = rt;
    branch_taken = br; mem_req = req; mem_ready = rdy;
    e = model_out(rst, ld, rd, rs, rt, br, req, rdy);
    q.push_back(e);
    model_step(rst, req, rdy, e);
    cyc++;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("enables", 32'({pc_en, ifid_en, idex_en, exmem_en, memwb_en}), 32'(e.en));
        check("flushes", 32'({ifid_flush, idex_flush, memwb_bubble}), 32'(e.fl));
        check("timeout_err", 32'(mem_timeout_err), 32'(e.err));
        check("state", 32'(state), 32'(e.st));
        check("stall_cnt", 32'(stall_cnt), 32'(e.sc));
      end
    end
  end

  initial begin
    int pct;
    // reset
    repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
    // load r5, ID reads r5: one bubble, then stall_cnt shows 1
    drive(1, 1, 5, 5, 0, 0, 0, 0);
    drive(1, 0, 5, 5, 0, 0, 0, 0);
    // load r0 with ID reading r0: no stall
    drive(1, 1, 0, 0, 0, 0, 0, 0);
    // load-use via rt
    drive(1, 1, 7, 1, 7, 0, 0, 0);
    // branch overrides load-use
    drive(1, 1, 5, 5, 5, 1, 0, 0);
    // memory busy for 3 cycles, ready on the 4th, with hazard held during the stall
    repeat (3) drive(1, 1, 9, 9, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 1, 9, 9, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // ready arriving exactly on the last tolerated wait cycle returns to RUN
    repeat (TO) drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 1, 1, 1);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // timeout: sticky error, cleared only by reset
    repeat (TO + 6) drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 1, 1);
    drive(1, 1, 3, 3, 3, 1, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // reset in the middle of a memory wait
    repeat (4) drive(1, 0, 0, 0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 0, 0, 1, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    // random traffic, memory-ready density varied per block to reach timeouts
    pct = 40;
    for (int i = 0; i < 3000; i++) begin
      if (i % 50 == 0) begin
        case ($urandom_range(0, 2))
          0: pct = 3;
          1: pct = 40;
          default: pct = 90;
        endcase
      end
      drive(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 1) == 1),
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 4) == 0),
            ($urandom_range(0, 99) < pct));
    end
    // saturation: hazard held for more than 2^16 cycles
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (SC_MAX + 5) drive(1, 1, 4, 4, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
